// File: rtl/monpro_pkg.sv
// rtl/monpro_pkg.sv - shared Montgomery datapath defaults, word type and final-subtract FSM states
package monpro_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int TOTAL_ADDR = 128;

  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    DECIDE = 2'd1,
    EMIT   = 2'd2
  } state_t;

endpackage

// File: rtl/sub_borrow.sv
// rtl/sub_borrow.sv - combinational word subtract with borrow in/out: {bout, d} = a - b - bin
module sub_borrow #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  assign {bout, d} = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};

endmodule

// File: rtl/monpro_final_sub.sv
// rtl/monpro_final_sub.sv - word-serial final conditional subtract r = (t >= n) ? t - n : t
// Optional FINAL_SUB_ERR_EN adds err, flagging an out-of-range top word t[s] > 1.
module monpro_final_sub #(
  parameter int DATA_WIDTH = monpro_pkg::DATA_WIDTH,
  parameter int TOTAL_ADDR = monpro_pkg::TOTAL_ADDR,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] t_word,
  input  logic [DATA_WIDTH-1:0] n_word,
  input  logic [DATA_WIDTH-1:0] t_top,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_word,
  output logic                  out_last,
  output logic                  busy
`ifdef FINAL_SUB_ERR_EN
  ,
  output logic                  err
`endif
);
  import monpro_pkg::*;

  localparam int IW = $clog2(TOTAL_ADDR);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTAL_ADDR - 1);

  state_t                state, state_next;
  logic [ADDR_W-1:0]     idx;
  logic [IW-1:0]         widx;
  logic                  borrow;
  logic                  sel_diff;
  logic [DATA_WIDTH-1:0] t_top_q;
  logic [DATA_WIDTH-1:0] diff;
  logic                  borrow_out;
  logic                  idx_at_end;
  logic [DATA_WIDTH-1:0] t_mem [TOTAL_ADDR];
  logic [DATA_WIDTH-1:0] d_mem [TOTAL_ADDR];

  // The word count alone terminates ACCEPT, so in_last carries no control information here.
  logic unused_in_last;
  assign unused_in_last = in_last;

  assign widx       = idx[IW-1:0];
  assign idx_at_end = (idx == LAST_IDX);

  sub_borrow #(.WIDTH(DATA_WIDTH)) u_sub (
    .a    (t_word),
    .b    (n_word),
    .bin  (borrow),
    .d    (diff),
    .bout (borrow_out)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ACCEPT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      ACCEPT: begin
        in_ready = 1'b1;
        busy     = (idx != '0);
        if (in_valid && idx_at_end) state_next = DECIDE;
      end
      DECIDE: state_next = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && idx_at_end) state_next = ACCEPT;
      end
      default: state_next = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      borrow   <= 1'b0;
      sel_diff <= 1'b0;
      t_top_q  <= '0;
    end else begin
      case (state)
        ACCEPT: if (in_valid) begin
          borrow <= borrow_out;
          idx    <= idx + 1'b1;
          if (idx_at_end) t_top_q <= t_top;
        end
        DECIDE: begin
          // A nonzero top word absorbs the final borrow, so t >= n in that case too.
          sel_diff <= (t_top_q != '0) | ~borrow;
          idx      <= '0;
        end
        EMIT: if (out_ready) begin
          if (idx_at_end) begin
            idx    <= '0;
            borrow <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: idx <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == ACCEPT && in_valid) begin
      t_mem[widx] <= t_word;
      d_mem[widx] <= diff;
    end
  end

  assign out_word = (state == EMIT) ? (sel_diff ? d_mem[widx] : t_mem[widx]) : '0;
  assign out_last = (state == EMIT) && idx_at_end;

`ifdef FINAL_SUB_ERR_EN
  always_ff @(posedge clk) begin
    if (reset)                err <= 1'b0;
    else if (state == DECIDE) err <= (t_top_q > DATA_WIDTH'(1));
  end
`endif

endmodule

// File: tb/tb_monpro_final_sub.sv
// tb/tb_monpro_final_sub.sv - scoreboard bench for monpro_final_sub at 8-bit words, 4 words per operand
module tb_monpro_final_sub;

  localparam int DW = 8;
  localparam int TA = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [DW-1:0] t_word;
  logic [DW-1:0] n_word;
  logic [DW-1:0] t_top;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_word;
  logic          out_last;
  logic          busy;
`ifdef FINAL_SUB_ERR_EN
  logic          err;
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [DW-1:0] exp_q[$];

  monpro_final_sub #(.DATA_WIDTH(DW), .TOTAL_ADDR(TA), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .t_word    (t_word),
    .n_word    (n_word),
    .t_top     (t_top),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_last  (out_last),
    .busy      (busy)
`ifdef FINAL_SUB_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pushes the reference result, then drives four word pairs LS first.
  task automatic send(input logic [31:0] t, input logic [31:0] n, input logic [7:0] top,
                      input logic [3:0] last_mask);
    logic [39:0] tw, nw, r;
    tw = {top, t};
    nw = {8'h00, n};
    r  = (tw >= nw) ? tw - nw : tw;
    for (int j = 0; j < TA; j++) exp_q.push_back(r[8*j +: 8]);
    for (int j = 0; j < TA; j++) begin
      @(negedge clk);
      check("in_ready_accept", in_ready, 1);
      in_valid = 1'b1;
      t_word   = t[8*j +: 8];
      n_word   = n[8*j +: 8];
      in_last  = last_mask[j];
      t_top    = top;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    t_top    = '0;
  endtask

  // Called in the cycle after the last input handshake; pattern bit i is out_ready on the i-th valid cycle.
  task automatic receive(input logic [15:0] pattern, input int plen);
    int   cyc;
    int   pos;
    int   delivered;
    logic stalled;
    logic [DW-1:0] held_word;
    logic held_last;
    logic [DW-1:0] exp_word;
    check("decide_out_valid", out_valid, 0);
    check("decide_in_ready", in_ready, 0);
    check("decide_busy", busy, 1);
    cyc = 0;
    while (!out_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check("first_valid_latency", cyc + 1, 2);
    pos       = 0;
    delivered = 0;
    stalled   = 1'b0;
    held_word = '0;
    held_last = 1'b0;
    for (int k = 0; k < 40 && delivered < TA; k++) begin
      out_ready = (pos < plen) ? pattern[pos] : 1'b1;
      pos++;
      check("emit_in_ready", in_ready, 0);
      check("emit_out_valid", out_valid, 1);
      if (stalled) begin
        check("stall_word_stable", out_word, held_word);
        check("stall_last_stable", out_last, held_last);
      end
      if (out_ready) begin
        exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("out_word", out_word, exp_word);
        check("out_last", out_last, (delivered == TA - 1));
        delivered++;
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        held_word = out_word;
        held_last = out_last;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("words_delivered", delivered, TA);
    check("scoreboard_empty", exp_q.size(), 0);
    check("back_to_back_in_ready", in_ready, 1);
    check("back_to_back_out_valid", out_valid, 0);
    check("back_to_back_busy", busy, 0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    t_word    = '0;
    n_word    = '0;
    t_top     = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_out_word", out_word, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;

    send(32'h04030201, 32'h04030200, 8'h00, 4'b1000);
    receive(16'h0000, 0);
    send(32'h01000000, 32'h02000000, 8'h00, 4'b1000);
    receive(16'h0000, 0);
    send(32'h00000005, 32'hFFFFFFF0, 8'h01, 4'b1000);
    receive(16'h0000, 0);
    send(32'h55AA55AA, 32'h55AA55AA, 8'h00, 4'b1000);
    receive(16'h0000, 0);
    // out_ready = 1,0,0,1,0,1,1 on successive valid cycles
    send(32'h04030201, 32'h04030200, 8'h00, 4'b1000);
    receive(16'b1101001, 7);
    // Misplaced in_last on word 1 must be ignored.
    send(32'h04030201, 32'h04030200, 8'h00, 4'b0010);
    receive(16'h0000, 0);

    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      in_valid = 1'b1;
      t_word   = 8'h11 * DW'(j + 1);
      n_word   = 8'h01;
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    send(32'h00000005, 32'hFFFFFFF0, 8'h01, 4'b1000);
    receive(16'h0000, 0);

    send(32'h00000005, 32'hFFFFFFF0, 8'h02, 4'b1000);
    receive(16'h0000, 0);
`ifdef FINAL_SUB_ERR_EN
    check("err_set", err, 1);
    send(32'h04030201, 32'h04030200, 8'h00, 4'b1000);
    receive(16'h0000, 0);
    check("err_cleared", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
